// File: rtl/matrix_mult_scheduler.sv
// Round-robin scheduler sharing one MAC matrix-multiply datapath among NREQ requesters.
// Sequences i/j/k over O = A*B and drives accumulator clear/enable and result write strobes.
module matrix_mult_scheduler #(
    parameter int NREQ     = 2,
    parameter int AROWS    = 3,
    parameter int ACOLUMNS = 3,
    parameter int BCOLUMNS = 3,
    parameter int IDXW     = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            abort,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] done,
    output logic            busy,
    output logic [IDXW-1:0] idx_i,
    output logic [IDXW-1:0] idx_j,
    output logic [IDXW-1:0] idx_k,
    output logic            mac_en,
    output logic            mac_clear,
    output logic            res_we,
    output logic [IDXW-1:0] res_i,
    output logic [IDXW-1:0] res_j
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   pick;
    logic [PW-1:0]   ptr_next;
    logic [NREQ-1:0] pick_oh;
    logic            last_i, last_j, last_k;
    int              cand;

    // Walk offsets from high to low so the lowest offset from ptr wins.
    always_comb begin
        pick    = '0;
        pick_oh = '0;
        cand    = 0;
        for (int o = NREQ - 1; o >= 0; o--) begin
            cand = int'(ptr) + o;
            if (cand >= NREQ) cand = cand - NREQ;
            if (req[cand]) begin
                pick          = PW'(cand);
                pick_oh       = '0;
                pick_oh[cand] = 1'b1;
            end
        end
    end

    assign ptr_next = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
    assign last_i   = (idx_i == IDXW'(AROWS - 1));
    assign last_j   = (idx_j == IDXW'(BCOLUMNS - 1));
    assign last_k   = (idx_k == IDXW'(ACOLUMNS - 1));
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            owner     <= '0;
            gnt       <= '0;
            done      <= '0;
            idx_i     <= '0;
            idx_j     <= '0;
            idx_k     <= '0;
            mac_en    <= 1'b0;
            mac_clear <= 1'b0;
            res_we    <= 1'b0;
            res_i     <= '0;
            res_j     <= '0;
        end else begin
            done   <= '0;
            // Result write trails the final k issue of each element by one cycle.
            res_we <= mac_en && last_k;
            res_i  <= (mac_en && last_k) ? idx_i : '0;
            res_j  <= (mac_en && last_k) ? idx_j : '0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        state     <= S_RUN;
                        gnt       <= pick_oh;
                        owner     <= pick;
                        mac_en    <= 1'b1;
                        mac_clear <= 1'b1;
                        idx_i     <= '0;
                        idx_j     <= '0;
                        idx_k     <= '0;
                    end
                end
                S_RUN: begin
                    if (last_i && last_j && last_k) begin
                        state     <= S_DRAIN;
                        mac_en    <= 1'b0;
                        mac_clear <= 1'b0;
                        idx_i     <= '0;
                        idx_j     <= '0;
                        idx_k     <= '0;
                    end else if (last_k) begin
                        idx_k     <= '0;
                        mac_clear <= 1'b1;
                        if (last_j) begin
                            idx_j <= '0;
                            idx_i <= idx_i + 1'b1;
                        end else begin
                            idx_j <= idx_j + 1'b1;
                        end
                    end else begin
                        idx_k     <= idx_k + 1'b1;
                        mac_clear <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    state <= S_FIN;
                    done  <= gnt;
                end
                S_FIN: begin
                    state <= S_IDLE;
                    gnt   <= '0;
                    ptr   <= ptr_next;
                end
                default: state <= S_IDLE;
            endcase
            // Cancel overrides everything above; the owner still loses priority.
            if (abort && state != S_IDLE) begin
                state     <= S_IDLE;
                gnt       <= '0;
                done      <= '0;
                mac_en    <= 1'b0;
                mac_clear <= 1'b0;
                idx_i     <= '0;
                idx_j     <= '0;
                idx_k     <= '0;
                res_we    <= 1'b0;
                res_i     <= '0;
                res_j     <= '0;
                ptr       <= ptr_next;
            end
        end
    end
endmodule

// File: tb/tb_matrix_mult_scheduler.sv
// Directed bench for matrix_mult_scheduler: default 3x3x3 instance plus an inner-dimension-1 instance.
module tb_matrix_mult_scheduler;
    logic       clock, reset, abort, abort1;
    logic [1:0] req, gnt, done, req1, gnt1, done1;
    logic       busy, mac_en, mac_clear, res_we;
    logic       busy1, mac_en1, mac_clear1, res_we1;
    logic [7:0] idx_i, idx_j, idx_k, res_i, res_j;
    logic [7:0] idx_i1, idx_j1, idx_k1, res_i1, res_j1;
    int vectors = 0;
    int miscompares = 0;

    matrix_mult_scheduler u0 (
        .clock(clock), .reset(reset), .req(req), .abort(abort), .gnt(gnt), .done(done),
        .busy(busy), .idx_i(idx_i), .idx_j(idx_j), .idx_k(idx_k), .mac_en(mac_en),
        .mac_clear(mac_clear), .res_we(res_we), .res_i(res_i), .res_j(res_j));

    matrix_mult_scheduler #(.NREQ(2), .AROWS(2), .ACOLUMNS(1), .BCOLUMNS(2), .IDXW(8)) u1 (
        .clock(clock), .reset(reset), .req(req1), .abort(abort1), .gnt(gnt1), .done(done1),
        .busy(busy1), .idx_i(idx_i1), .idx_j(idx_j1), .idx_k(idx_k1), .mac_en(mac_en1),
        .mac_clear(mac_clear1), .res_we(res_we1), .res_i(res_i1), .res_j(res_j1));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; req1 = '0; abort = 1'b0; abort1 = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({gnt, done, busy, mac_en, mac_clear, res_we} !== 8'h00 ||
            {idx_i, idx_j, idx_k, res_i, res_j} !== 40'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: gnt=%b done=%b busy=%b mac_en=%b res_we=%b idx=%0d/%0d/%0d, required all 0",
                     gnt, done, busy, mac_en, res_we, idx_i, idx_j, idx_k);
        end
    endtask

    task automatic test_single_job();
        int wr [3][3];
        int e, xi, xj, xk, xri, xrj;
        logic xmac, xclr, xwe;
        logic [1:0] xgnt, xdone;
        for (int a = 0; a < 3; a++) for (int b = 0; b < 3; b++) wr[a][b] = 0;
        do_reset();
        req = 2'b01;
        for (int c = 1; c <= 31; c++) begin
            tick();
            if (c == 1) req = 2'b00;
            e    = c - 1;
            xgnt = (c <= 29) ? 2'b01 : 2'b00;
            xdone = (c == 29) ? 2'b01 : 2'b00;
            xmac = (c <= 27);
            xi   = xmac ? e / 9 : 0;
            xj   = xmac ? (e / 3) % 3 : 0;
            xk   = xmac ? e % 3 : 0;
            xclr = xmac && (xk == 0);
            xwe  = (c >= 4) && (c <= 28) && ((c - 4) % 3 == 0);
            xri  = xwe ? (c - 4) / 9 : 0;
            xrj  = xwe ? ((c - 4) / 3) % 3 : 0;
            vectors++;
            if (gnt !== xgnt || done !== xdone || busy !== (c <= 29)) begin
                miscompares++;
                $display("FAIL job_handshake c=%0d: gnt=%b done=%b busy=%b, required gnt=%b done=%b busy=%b",
                         c, gnt, done, busy, xgnt, xdone, (c <= 29));
            end
            vectors++;
            if (mac_en !== xmac || mac_clear !== xclr || idx_i !== 8'(xi) || idx_j !== 8'(xj) || idx_k !== 8'(xk)) begin
                miscompares++;
                $display("FAIL job_issue c=%0d: en=%b clr=%b ijk=%0d,%0d,%0d, required en=%b clr=%b ijk=%0d,%0d,%0d",
                         c, mac_en, mac_clear, idx_i, idx_j, idx_k, xmac, xclr, xi, xj, xk);
            end
            vectors++;
            if (res_we !== xwe || res_i !== 8'(xri) || res_j !== 8'(xrj)) begin
                miscompares++;
                $display("FAIL job_result c=%0d: we=%b res=%0d,%0d, required we=%b res=%0d,%0d",
                         c, res_we, res_i, res_j, xwe, xri, xrj);
            end
            vectors++;
            if (!$onehot0(gnt)) begin
                miscompares++;
                $display("FAIL gnt_onehot c=%0d: gnt=%b, required one-hot or 0", c, gnt);
            end
            if (res_we === 1'b1) begin
                vectors++;
                if (res_i >= 8'd3 || res_j >= 8'd3) begin
                    miscompares++;
                    $display("FAIL res_range c=%0d: res=%0d,%0d, required both < 3", c, res_i, res_j);
                end else begin
                    wr[res_i][res_j]++;
                end
            end
        end
        for (int a = 0; a < 3; a++) for (int b = 0; b < 3; b++) begin
            vectors++;
            if (wr[a][b] != 1) begin
                miscompares++;
                $display("FAIL write_once (%0d,%0d): writes=%0d, required 1", a, b, wr[a][b]);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req = 2'b11;
        for (int c = 1; c <= 61; c++) begin
            tick();
            vectors++;
            if (!$onehot0(gnt)) begin
                miscompares++;
                $display("FAIL rr_onehot c=%0d: gnt=%b, required one-hot or 0", c, gnt);
            end
            if (c == 1 || c == 31 || c == 61) begin
                vectors++;
                if (gnt !== ((c == 31) ? 2'b10 : 2'b01)) begin
                    miscompares++;
                    $display("FAIL rr_grant c=%0d: gnt=%b, required %b", c, gnt, (c == 31) ? 2'b10 : 2'b01);
                end
            end
            if (c == 29 || c == 59) begin
                vectors++;
                if (done !== ((c == 29) ? 2'b01 : 2'b10)) begin
                    miscompares++;
                    $display("FAIL rr_done c=%0d: done=%b, required %b", c, done, (c == 29) ? 2'b01 : 2'b10);
                end
            end
            if (c == 30) begin
                vectors++;
                if (gnt !== 2'b00 || busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rr_gap c=30: gnt=%b busy=%b, required 00 0", gnt, busy);
                end
            end
        end
        req = 2'b00;
    endtask

    task automatic test_abort();
        do_reset();
        req = 2'b01;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 1) req = 2'b00;
            vectors++;
            if (done !== 2'b00) begin
                miscompares++;
                $display("FAIL abort_no_done c=%0d: done=%b, required 00", c, done);
            end
            if (c == 10) begin
                vectors++;
                if (res_we !== 1'b1 || gnt !== 2'b01) begin
                    miscompares++;
                    $display("FAIL abort_pre c=10: res_we=%b gnt=%b, required 1 01", res_we, gnt);
                end
                abort = 1'b1;
            end
            if (c == 11) begin
                abort = 1'b0;
                vectors++;
                if (gnt !== 2'b00 || busy !== 1'b0 || mac_en !== 1'b0 || res_we !== 1'b0 || idx_i !== 8'd0) begin
                    miscompares++;
                    $display("FAIL abort_idle c=11: gnt=%b busy=%b mac_en=%b res_we=%b idx_i=%0d, required all 0",
                             gnt, busy, mac_en, res_we, idx_i);
                end
                req = 2'b11;
            end
            if (c == 12) begin
                vectors++;
                if (gnt !== 2'b10 || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL abort_next_grant c=12: gnt=%b busy=%b, required 10 1", gnt, busy);
                end
            end
        end
        req = 2'b00;
    endtask

    task automatic test_inner_one();
        logic xmac, xwe, xbusy;
        int xi, xj, xri, xrj;
        do_reset();
        req1 = 2'b01;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) req1 = 2'b00;
            xmac  = (c <= 4);
            xi    = xmac ? (c - 1) / 2 : 0;
            xj    = xmac ? (c - 1) % 2 : 0;
            xwe   = (c >= 2) && (c <= 5);
            xri   = xwe ? (c - 2) / 2 : 0;
            xrj   = xwe ? (c - 2) % 2 : 0;
            xbusy = (c <= 6);
            vectors++;
            if (mac_en1 !== xmac || mac_clear1 !== xmac || idx_i1 !== 8'(xi) || idx_j1 !== 8'(xj) || idx_k1 !== 8'd0) begin
                miscompares++;
                $display("FAIL k1_issue c=%0d: en=%b clr=%b ijk=%0d,%0d,%0d, required en=%b clr=%b ijk=%0d,%0d,0",
                         c, mac_en1, mac_clear1, idx_i1, idx_j1, idx_k1, xmac, xmac, xi, xj);
            end
            vectors++;
            if (res_we1 !== xwe || res_i1 !== 8'(xri) || res_j1 !== 8'(xrj)) begin
                miscompares++;
                $display("FAIL k1_result c=%0d: we=%b res=%0d,%0d, required we=%b res=%0d,%0d",
                         c, res_we1, res_i1, res_j1, xwe, xri, xrj);
            end
            vectors++;
            if (done1 !== ((c == 6) ? 2'b01 : 2'b00) || busy1 !== xbusy) begin
                miscompares++;
                $display("FAIL k1_done c=%0d: done=%b busy=%b, required done=%b busy=%b",
                         c, done1, busy1, (c == 6) ? 2'b01 : 2'b00, xbusy);
            end
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        req = 2'b01;
        for (int c = 1; c <= 37; c++) begin
            tick();
            if (c == 1) req = 2'b00;
            if (c == 30) req = 2'b10;
            if (c == 31) begin
                req = 2'b00;
                vectors++;
                if (gnt !== 2'b10) begin
                    miscompares++;
                    $display("FAIL midrun_setup c=31: gnt=%b, required 10", gnt);
                end
            end
            if (c == 35) reset = 1'b1;
            if (c == 36) begin
                vectors++;
                if ({gnt, done, busy, mac_en, mac_clear, res_we} !== 8'h00 ||
                    {idx_i, idx_j, idx_k, res_i, res_j} !== 40'h0) begin
                    miscompares++;
                    $display("FAIL midrun_reset c=36: gnt=%b busy=%b mac_en=%b idx=%0d/%0d/%0d, required all 0",
                             gnt, busy, mac_en, idx_i, idx_j, idx_k);
                end
                reset = 1'b0;
                req   = 2'b11;
            end
            if (c == 37) begin
                vectors++;
                if (gnt !== 2'b01) begin
                    miscompares++;
                    $display("FAIL midrun_ptr c=37: gnt=%b, required 01", gnt);
                end
            end
        end
        req = 2'b00;
    endtask

    initial begin
        reset = 1'b1; req = '0; req1 = '0; abort = 1'b0; abort1 = 1'b0;
        test_reset();
        test_single_job();
        test_round_robin();
        test_abort();
        test_inner_one();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
